// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch control, instruction-memory and decode handshake bundle
interface instr_fetch_if #(parameter int width = 32);
  logic fetch_en;
  logic redirect_valid;
  logic [width-1:0] redirect_pc;
  logic [width-1:0] imem_addr;
  logic [width-1:0] imem_data;
  logic instr_valid;
  logic instr_ready;
  logic [width-1:0] instr_out;
  logic [width-1:0] pc_out;
  modport master (
    output fetch_en, redirect_valid, redirect_pc, imem_data, instr_ready,
    input imem_addr, instr_valid, instr_out, pc_out
  );
  modport slave (
    input fetch_en, redirect_valid, redirect_pc, imem_data, instr_ready,
    output imem_addr, instr_valid, instr_out, pc_out
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: sequential fetch with one response in flight, 2-entry {pc, instr} queue and redirect flush
module instr_fetch #(
  parameter int width = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.slave bus
);
  logic [width-1:0] pc;
  logic [width-1:0] rsp_pc;
  logic rsp_pending;
  logic [width-1:0] fifo_pc [2];
  logic [width-1:0] fifo_instr [2];
  logic [1:0] count;
  logic rd_ptr;
  logic wr_ptr;
  logic pop;
  logic push;
  logic issue;
  logic [2:0] occ;
  assign bus.imem_addr = pc;
  assign bus.instr_valid = (count != 2'd0) && !bus.redirect_valid;
  assign bus.instr_out = fifo_instr[rd_ptr];
  assign bus.pc_out = fifo_pc[rd_ptr];
  // Issue only if the queue can absorb the new response plus any already in flight.
  always_comb begin
    pop = bus.instr_valid && bus.instr_ready;
    push = rsp_pending && !bus.redirect_valid;
    occ = {1'b0, count} + {2'b0, rsp_pending} - {2'b0, pop};
    issue = bus.fetch_en && !bus.redirect_valid && (occ < 3'd2);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      rsp_pc <= '0;
      rsp_pending <= 1'b0;
      count <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      fifo_pc <= '{default: '0};
      fifo_instr <= '{default: '0};
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc & ~width'(3);
      rsp_pending <= 1'b0;
      count <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      rsp_pending <= issue;
      if (issue) begin
        rsp_pc <= pc;
        pc <= pc + width'(4);
      end
      if (push) begin
        fifo_pc[wr_ptr] <= rsp_pc;
        fifo_instr[wr_ptr] <= bus.imem_data;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of latency, backpressure, redirect, fetch gating, wrap and reset
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  instr_fetch_if #(.width(32)) bus();
  instr_fetch #(.width(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h00000033 :
           a == 32'h4 ? 32'h00638433 :
           a == 32'h8 ? 32'h406384b3 :
           a >= 32'h20 ? 32'h0032a5b3 : {16'hc0de, a[15:0]};
  endfunction
  always @(posedge clk) bus.imem_data <= mem(bus.imem_addr);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
    chk({tag, "_pc"}, bus.pc_out, pc);
    chk({tag, "_instr"}, bus.instr_out, ins);
  endtask
  initial begin
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr_out, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    // cold start
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("cold_e0_valid", 32'(bus.instr_valid), 32'h0);
    chk("cold_e0_addr", bus.imem_addr, 32'h4);
    tick();
    chk_out("cold_0", 32'h0, 32'h00000033);
    tick();
    chk_out("cold_4", 32'h4, 32'h00638433);
    tick();
    chk_out("cold_8", 32'h8, 32'h406384b3);
    // backpressure from a fresh start
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk_out("bp_first", 32'h0, 32'h00000033);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp_hold", 32'h0, 32'h00000033);
      chk("bp_addr", bus.imem_addr, 32'h8);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk_out("bp_4", 32'h4, 32'h00638433);
    tick();
    chk_out("bp_8", 32'h8, 32'h406384b3);
    tick();
    chk_out("bp_12", 32'hc, 32'hc0de000c);
    // redirect while data is present and ready is high
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    #1;
    chk("redir_valid_low", 32'(bus.instr_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir_addr", bus.imem_addr, 32'h20);
    chk("redir_flushed", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("redir_e1_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk_out("redir_20", 32'h20, 32'h0032a5b3);
    tick();
    chk_out("redir_24", 32'h24, 32'h0032a5b3);
    // fetch_en low for three cycles
    bus.fetch_en = 1'b0;
    tick();
    chk_out("fen_inflight", 32'h28, 32'h0032a5b3);
    tick();
    chk("fen_drained", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("fen_idle", 32'(bus.instr_valid), 32'h0);
    chk("fen_addr", bus.imem_addr, 32'h2c);
    bus.fetch_en = 1'b1;
    tick();
    chk("fen_resume_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk_out("fen_2c", 32'h2c, 32'h0032a5b3);
    // wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hfffffffe;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_top", bus.imem_addr, 32'hfffffffc);
    tick();
    chk("wrap_addr_zero", bus.imem_addr, 32'h0);
    tick();
    chk_out("wrap_top", 32'hfffffffc, 32'h0032a5b3);
    tick();
    chk_out("wrap_zero", 32'h0, 32'h00000033);
    // asynchronous reset with the queue full
    bus.instr_ready = 1'b0;
    tick();
    chk_out("full_head", 32'h0, 32'h00000033);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_pc", bus.pc_out, 32'h0);
    chk("arst_instr", bus.instr_out, 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    tick();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chk("restart_valid", 32'(bus.instr_valid), 32'h0);
    chk("restart_addr", bus.imem_addr, 32'h4);
    tick();
    chk_out("restart_0", 32'h0, 32'h00000033);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
